// File: rtl/alu_mdu_seq.sv
// EX-stage execution unit: WIDTH-bit ALUFun ALU plus iterative multiplier/divider behind one valid/ready stage.
// The divider is built only when ALU_MDU_SEQ_DIV_EN is defined; otherwise md=10 reports err like the reserved code.
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  input  logic [5:0]       alu_fun,
  input  logic [1:0]       md,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_hi,
  output logic             ovf,
  output logic             err
);
  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next, opb_reg, opb_next;
  logic [WIDTH-1:0] z_reg, z_next, z_hi_reg, z_hi_next;
  logic             ovf_reg, ovf_next, err_reg, err_next;
  logic             neg_q_reg, neg_q_next;
`ifdef ALU_MDU_SEQ_DIV_EN
  logic             div_reg, div_next, neg_r_reg, neg_r_next, div0_reg, div0_next;
  logic [WIDTH-1:0] a_reg, a_next;
`endif

  // ALU, evaluated straight from the request so the result registers on the accept edge
  logic [WIDTH-1:0] alu_z, sum;
  logic             alu_ovf, a_zero, lt;
  logic [SH_W-1:0]  shamt;

  assign shamt  = a[SH_W-1:0];
  assign a_zero = (a == '0);
  assign lt     = sign ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    alu_z   = '0;
    alu_ovf = 1'b0;
    sum     = alu_fun[0] ? (a - b) : (a + b);
    case (alu_fun[5:4])
      2'b00: begin
        alu_z   = sum;
        alu_ovf = sign & (alu_fun[0] ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
                       & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        case (alu_fun[3:0])
          4'b1000: alu_z = a & b;
          4'b1110: alu_z = a | b;
          4'b0110: alu_z = a ^ b;
          4'b0001: alu_z = ~(a | b);
          4'b1010: alu_z = a;
          default: alu_z = '0;
        endcase
      end
      2'b10: begin
        case (alu_fun[1:0])
          2'b00:   alu_z = b << shamt;
          2'b01:   alu_z = b >> shamt;
          2'b11:   alu_z = $unsigned($signed(b) >>> shamt);
          default: alu_z = '0;
        endcase
      end
      default: begin
        case (alu_fun[3:1])
          3'b001:  alu_z = {{(WIDTH-1){1'b0}}, (a == b)};
          3'b000:  alu_z = {{(WIDTH-1){1'b0}}, (a != b)};
          3'b010:  alu_z = {{(WIDTH-1){1'b0}}, lt};
          3'b110:  alu_z = {{(WIDTH-1){1'b0}}, (a[WIDTH-1] | a_zero)};
          3'b101:  alu_z = {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
          3'b111:  alu_z = {{(WIDTH-1){1'b0}}, (~a[WIDTH-1] & ~a_zero)};
          default: alu_z = '0;
        endcase
      end
    endcase
  end

  // One shared iteration unit; in IDLE it is fed the fresh magnitudes so the accept edge does the first step
  logic [WIDTH-1:0] mag_a, mag_b, st_hi, st_lo, st_opb;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo, step_hi, step_lo;
  logic [2*WIDTH-1:0] mul_prod, mul_fix;

  assign mag_a = (sign && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sign && b[WIDTH-1]) ? -b : b;

`ifdef ALU_MDU_SEQ_DIV_EN
  logic             st_div, div_ge;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub, div_hi, div_lo;

  always_comb begin
    if (state_reg == IDLE) begin
      st_div = (md == 2'b10);
      st_hi  = '0;
      st_lo  = st_div ? mag_a : mag_b;
      st_opb = st_div ? mag_b : mag_a;
    end else begin
      st_div = div_reg;
      st_hi  = hi_reg;
      st_lo  = lo_reg;
      st_opb = opb_reg;
    end
  end

  assign div_shift = {st_hi, st_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, st_opb});
  assign div_sub   = div_shift[WIDTH-1:0] - st_opb;
  assign div_hi    = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_lo    = {st_lo[WIDTH-2:0], div_ge};
  assign step_hi   = st_div ? div_hi : mul_hi;
  assign step_lo   = st_div ? div_lo : mul_lo;
`else
  always_comb begin
    if (state_reg == IDLE) begin
      st_hi  = '0;
      st_lo  = mag_b;
      st_opb = mag_a;
    end else begin
      st_hi  = hi_reg;
      st_lo  = lo_reg;
      st_opb = opb_reg;
    end
  end

  assign step_hi = mul_hi;
  assign step_lo = mul_lo;
`endif

  assign mul_sum  = {1'b0, st_hi} + (st_lo[0] ? {1'b0, st_opb} : '0);
  assign mul_hi   = mul_sum[WIDTH:1];
  assign mul_lo   = {mul_sum[0], st_lo[WIDTH-1:1]};
  assign mul_prod = {mul_hi, mul_lo};
  assign mul_fix  = neg_q_reg ? -mul_prod : mul_prod;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    opb_next   = opb_reg;
    z_next     = z_reg;
    z_hi_next  = z_hi_reg;
    ovf_next   = ovf_reg;
    err_next   = err_reg;
    neg_q_next = neg_q_reg;
`ifdef ALU_MDU_SEQ_DIV_EN
    div_next   = div_reg;
    neg_r_next = neg_r_reg;
    div0_next  = div0_reg;
    a_next     = a_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          ovf_next  = 1'b0;
          err_next  = 1'b0;
          z_hi_next = '0;
          if (md == 2'b00) begin
            z_next     = alu_z;
            ovf_next   = alu_ovf;
            state_next = DONE;
`ifdef ALU_MDU_SEQ_DIV_EN
          end else if (md == 2'b01 || md == 2'b10) begin
            div_next   = md[1];
            neg_r_next = sign & a[WIDTH-1];
            div0_next  = (b == '0);
            a_next     = a;
`else
          end else if (md == 2'b01) begin
`endif
            hi_next    = step_hi;
            lo_next    = step_lo;
            opb_next   = st_opb;
            neg_q_next = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_next   = CNT_W'(WIDTH);
            state_next = CALC;
          end else begin
            z_next     = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      CALC: begin
        hi_next  = step_hi;
        lo_next  = step_lo;
        cnt_next = cnt_reg - CNT_W'(1);
        // Counter reaches 1 on the last of WIDTH steps (the first ran on the accept edge)
        if (cnt_reg == CNT_W'(2)) begin
          state_next = DONE;
          {z_hi_next, z_next} = mul_fix;
`ifdef ALU_MDU_SEQ_DIV_EN
          if (div_reg) begin
            if (div0_reg) begin
              z_next    = '1;
              z_hi_next = a_reg;
              err_next  = 1'b1;
            end else begin
              z_next    = neg_q_reg ? -div_lo : div_lo;
              z_hi_next = neg_r_reg ? -div_hi : div_hi;
            end
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opb_reg   <= '0;
      z_reg     <= '0;
      z_hi_reg  <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
`ifdef ALU_MDU_SEQ_DIV_EN
      div_reg   <= 1'b0;
      neg_r_reg <= 1'b0;
      div0_reg  <= 1'b0;
      a_reg     <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      opb_reg   <= opb_next;
      z_reg     <= z_next;
      z_hi_reg  <= z_hi_next;
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
      neg_q_reg <= neg_q_next;
`ifdef ALU_MDU_SEQ_DIV_EN
      div_reg   <= div_next;
      neg_r_reg <= neg_r_next;
      div0_reg  <= div0_next;
      a_reg     <= a_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign z         = z_reg;
  assign z_hi      = z_hi_reg;
  assign ovf       = ovf_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: vector table through a scoreboard plus reset, stall and back-to-back sequences.
// Division expectations follow ALU_MDU_SEQ_DIV_EN the same way the design does.
module tb_alu_mdu_seq;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   m;
    logic         s;
    logic [5:0]   f;
    logic [W-1:0] va, vb, ez, eh;
    logic         eo, ee;
    int           lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, sign = 1'b0;
  logic         in_ready, out_valid, ovf, err;
  logic [W-1:0] a = '0, b = '0, z, z_hi;
  logic [5:0]   alu_fun = '0;
  logic [1:0]   md = '0;

  int   cyc = 0, checks = 0, fails = 0, txn = 0;
  bit   seen = 0;
  vec_t cur;
  exp_t pe, ce;
  exp_t sb[$];
  int   acc_log[$];
  vec_t tbl[$];

  alu_mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sign(sign), .alu_fun(alu_fun), .md(md),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_hi(z_hi), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (txn %0d): got %h, expected %h", name, txn, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic s, input logic [5:0] f,
                              input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] ez, input logic [W-1:0] eh,
                              input logic eo, input logic ee, input int lat);
    vec_t v;
    v.m = m; v.s = s; v.f = f; v.va = va; v.vb = vb;
    v.ez = ez; v.eh = eh; v.eo = eo; v.ee = ee; v.lat = lat;
    return v;
  endfunction

  function automatic vec_t mkdiv(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic [W-1:0] q, input logic [W-1:0] r, input logic ee);
`ifdef ALU_MDU_SEQ_DIV_EN
    return mk(2'b10, s, 6'd0, va, vb, q, r, 1'b0, ee, W);
`else
    return mk(2'b10, s, 6'd0, va, vb, '0, '0, 1'b0, 1'b1, 1);
`endif
  endfunction

  // Scoreboard: push on accept, check latency on first out_valid, compare on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        pe.v = cur;
        pe.acc = cyc;
        sb.push_back(pe);
        acc_log.push_back(cyc);
      end
      if (out_valid && !seen) begin
        seen = 1;
        if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].v.lat));
      end
      if (out_valid && out_ready) begin
        seen = 0;
        if (sb.size() != 0) begin
          ce = sb.pop_front();
          txn++;
          $display("txn %0d md=%b sign=%b fun=%b a=%h b=%h -> z=%h z_hi=%h ovf=%b err=%b",
                   txn, ce.v.m, ce.v.s, ce.v.f, ce.v.va, ce.v.vb, z, z_hi, ovf, err);
          chk("z", 64'(z), 64'(ce.v.ez));
          chk("z_hi", 64'(z_hi), 64'(ce.v.eh));
          chk("ovf", 64'(ovf), 64'(ce.v.eo));
          chk("err", 64'(err), 64'(ce.v.ee));
        end
      end
    end
  end

  // Drives one request and returns #1 after its accept edge with in_valid dropped
  task automatic issue(input vec_t v);
    int n;
    cur = v;
    md = v.m; sign = v.s; alu_fun = v.f; a = v.va; b = v.vb;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Arith / logic / shift / compare
    tbl.push_back(mk(2'b00, 1, 6'b000000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b000000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 1, 6'b000001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 1));
    tbl.push_back(mk(2'b00, 1, 6'b000001, 32'h5, 32'h7, 32'hFFFFFFFE, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b011000, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b011110, 32'hF0F00000, 32'h0000FFFF, 32'hF0F0FFFF, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b010110, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b010001, 32'hF0F00000, 32'h0000FFFF, 32'h0F0F0000, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b011010, 32'h12345678, 32'h9, 32'h12345678, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b010011, 32'h12345678, 32'h9, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b100000, 32'h4, 32'h80000011, 32'h00000110, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b100001, 32'h4, 32'h80000010, 32'h08000001, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b100011, 32'h4, 32'h80000010, 32'hF8000001, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b100001, 32'h24, 32'h80000010, 32'h08000001, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b100010, 32'h4, 32'h80000010, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b110010, 32'h5, 32'h5, 32'h1, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b110000, 32'h5, 32'h5, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b110101, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 1, 6'b110101, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b111100, 32'h0, 32'h7, 32'h1, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b111010, 32'h80000000, 32'h0, 32'h1, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b111110, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1));
    tbl.push_back(mk(2'b00, 0, 6'b111110, 32'h1, 32'h0, 32'h1, 0, 0, 0, 1));
    // Multiply
    tbl.push_back(mk(2'b01, 1, 6'd0, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, W));
    tbl.push_back(mk(2'b01, 0, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, W));
    tbl.push_back(mk(2'b01, 1, 6'd0, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 0, 0, W));
    tbl.push_back(mk(2'b01, 1, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, W));
    // Divide
    tbl.push_back(mkdiv(1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0));
    tbl.push_back(mkdiv(1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 0));
    tbl.push_back(mkdiv(0, 32'd100, 32'd7, 32'd14, 32'd2, 0));
    tbl.push_back(mkdiv(0, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h5, 1));
    tbl.push_back(mkdiv(1, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1));
    tbl.push_back(mkdiv(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0));
    // Reserved md
    tbl.push_back(mk(2'b11, 1, 6'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 0, 1, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_z", 64'(z), 64'd0);
    chk("reset_z_hi", 64'(z_hi), 64'd0);
    chk("reset_ovf_err", 64'({ovf, err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i]);
      drain();
    end

    // Stall: result held with out_ready low for 10 cycles
    out_ready = 1'b0;
    issue(tbl[23]);
    for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
    chk("stall_reached_done", 64'(out_valid), 64'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_z", 64'(z), 64'hFFFFFFEB);
      chk("stall_z_hi", 64'(z_hi), 64'hFFFFFFFF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset during the fifth CALC cycle of a multiply discards it
    issue(tbl[0]);
    drain();
    issue(tbl[24]);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    seen = 0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_z", 64'(z), 64'd0);
    chk("midreset_z_hi", 64'(z_hi), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(mk(2'b00, 0, 6'b000000, 32'h2, 32'h3, 32'h5, 0, 0, 0, 1));
    drain();

    // Back-to-back ADD, MUL, NE with in_valid held
    acc_log.delete();
    issue(mk(2'b00, 0, 6'b000000, 32'h10, 32'h20, 32'h30, 0, 0, 0, 1));
    issue(mk(2'b01, 0, 6'd0, 32'h3, 32'h5, 32'hF, 32'h0, 0, 0, W));
    issue(mk(2'b00, 0, 6'b110000, 32'h3, 32'h4, 32'h1, 0, 0, 0, 1));
    drain();
    chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap_add_mul", 64'(acc_log[1] - acc_log[0]), 64'd2);
      chk("b2b_gap_mul_ne", 64'(acc_log[2] - acc_log[1]), 64'(W + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
